custom_apb_key: RTL and testbench



---
 rtl/custom_io_pkg.sv | 14 +
 rtl/key_debounce.sv | 59 +++++
 rtl/custom_apb_key.sv | 66 ++++++
 tb/tb_custom_apb_key.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/custom_io_pkg.sv
// Constants shared between the board key core and the LED core wrapper.
package custom_io_pkg;

    // APB register word width seen by the wrappers
    localparam int DATA_W = 32;

    // Push-buttons are active-low: a high level means the key is released
    localparam logic KEY_RELEASED = 1'b1;

    // 20 ms at 50 MHz; the counter width must cover the terminal count
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_CNT_W           = 20;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debouncer and press-edge detector.
module key_debounce
    import custom_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic rawIn,
    output logic stableOut,
    output logic pressPulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ;
    logic             terminal;

    // Synchronised sample disagrees with the accepted level; the count runs only while so
    assign differ   = (sync_p1 != stable_q);
    assign terminal = differ && (cnt_q == CNT_LAST);

    // Two-flop synchroniser for the asynchronous board input, idling at released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= KEY_RELEASED;
            sync_p1 <= KEY_RELEASED;
        end else begin
            sync_p0 <= rawIn;
            sync_p1 <= sync_p0;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= KEY_RELEASED;
            cnt_q    <= '0;
        end else if (!differ) begin
            cnt_q    <= '0;
        end else if (terminal) begin
            stable_q <= sync_p1;
            cnt_q    <= '0;
        end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Press pulse is high in the cycle whose closing edge moves stable from released to pressed,
    // so the event register captures it on the same edge the level changes
    assign pressPulse = terminal && (stable_q == KEY_RELEASED);
    assign stableOut  = stable_q;

endmodule

// File: rtl/custom_apb_key.sv
// Board push-button core: per-key debouncers, sticky W1C press events and a level interrupt.
module custom_apb_key
    import custom_io_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keyIn,
    input  logic                clrEvt,
    input  logic [NUM_KEYS-1:0] clrMask,
    output logic [DATA_W-1:0]   keyLevel,
    output logic [DATA_W-1:0]   keyEvent,
    output logic                keyIrq
);

    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] pressEdge;
    logic [NUM_KEYS-1:0] evt_q;
    logic [NUM_KEYS-1:0] evt_next;
    logic [NUM_KEYS-1:0] clr_bits;
    logic                irq_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .rawIn      (keyIn[i]),
            .stableOut  (stable[i]),
            .pressPulse (pressEdge[i])
        );
    end

    // Next event state: clear masked bits, then set on press so a colliding press is kept
    always_comb begin
        clr_bits = clrEvt ? clrMask : '0;
        evt_next = (evt_q & ~clr_bits) | pressEdge;
    end

    // Sticky event bits and the interrupt, both taken from the same next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            evt_q <= evt_next;
            irq_q <= |evt_next;
        end
    end

    // Zero-extend to the bus word; level is pressed-high, the inverse of the stable flop
    always_comb begin
        keyLevel                 = '0;
        keyEvent                 = '0;
        keyLevel[NUM_KEYS-1:0]   = ~stable;
        keyEvent[NUM_KEYS-1:0]   = evt_q;
    end

    assign keyIrq = irq_q;

endmodule

// File: tb/tb_custom_apb_key.sv
// Directed bench for custom_apb_key with an 8-cycle debounce and four keys.
module tb_custom_apb_key;

    localparam int NUM_KEYS = 4;
    localparam int DEB      = 8;
    localparam int CW       = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NUM_KEYS-1:0] keyIn = 4'b1111;
    logic                clrEvt = 1'b0;
    logic [NUM_KEYS-1:0] clrMask = '0;
    logic [31:0]         keyLevel;
    logic [31:0]         keyEvent;
    logic                keyIrq;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    custom_apb_key #(
        .NUM_KEYS        (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keyIn    (keyIn),
        .clrEvt   (clrEvt),
        .clrMask  (clrMask),
        .keyLevel (keyLevel),
        .keyEvent (keyEvent),
        .keyIrq   (keyIrq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Advance n rising edges and land 1 ns after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single-cycle W1C strobe
    task automatic clear(input logic [NUM_KEYS-1:0] m);
        clrEvt  = 1'b1;
        clrMask = m;
        tick(1);
        clrEvt  = 1'b0;
        clrMask = '0;
    endtask

    initial begin
        // Reset with keys released
        tick(3);
        chk("rst_level", keyLevel, 32'h0);
        chk("rst_event", keyEvent, 32'h0);
        chk("rst_irq", {31'b0, keyIrq}, 32'h0);
        rst = 1'b1;
        tick(2);
        chk("idle_level", keyLevel, 32'h0);

        // Build up a pending event, then assert reset between edges
        keyIn = 4'b1110;
        tick(12);
        chk("pre_async_evt", keyEvent, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_level", keyLevel, 32'h0);
        chk("async_event", keyEvent, 32'h0);
        chk("async_irq", {31'b0, keyIrq}, 32'h0);
        keyIn = 4'b1111;
        tick(2);
        rst = 1'b1;
        tick(2);

        // Clean press on key 0: edge 0 is the edge just passed
        keyIn = 4'b1110;
        tick(9);
        chk("press_e9_level", keyLevel, 32'h0);
        chk("press_e9_event", keyEvent, 32'h0);
        tick(1);
        chk("press_e10_level", keyLevel, 32'h1);
        chk("press_e10_event", keyEvent, 32'h1);
        chk("press_e10_irq", {31'b0, keyIrq}, 32'h1);
        tick(20);
        keyIn = 4'b1111;
        tick(9);
        chk("rel_e39_level", keyLevel, 32'h1);
        tick(1);
        chk("rel_e40_level", keyLevel, 32'h0);
        chk("rel_e40_event", keyEvent, 32'h1);

        // Clears that must leave the event untouched
        clear(4'b0000);
        chk("clr_mask0", keyEvent, 32'h1);
        clear(4'b0010);
        chk("clr_nopend", keyEvent, 32'h1);
        clear(4'b0001);
        chk("clr_key0", keyEvent, 32'h0);
        chk("clr_key0_irq", {31'b0, keyIrq}, 32'h0);

        // Bounce on key 2: no low run reaches 8 samples
        keyIn = 4'b1011; tick(5);
        keyIn = 4'b1111; tick(1);
        keyIn = 4'b1011; tick(7);
        keyIn = 4'b1111;
        chk("bounce_mid_level", keyLevel, 32'h0);
        tick(15);
        chk("bounce_level", keyLevel, 32'h0);
        chk("bounce_event", keyEvent, 32'h0);

        // Keys 0 and 2 pressed together, then W1C one at a time
        keyIn = 4'b1010;
        tick(10);
        chk("k02_level", keyLevel, 32'h5);
        chk("k02_event", keyEvent, 32'h5);
        keyIn = 4'b1111;
        tick(12);
        chk("k02_rel_level", keyLevel, 32'h0);
        clear(4'b0001);
        chk("w1c_a_event", keyEvent, 32'h4);
        chk("w1c_a_irq", {31'b0, keyIrq}, 32'h1);
        clear(4'b0100);
        chk("w1c_b_event", keyEvent, 32'h0);
        chk("w1c_b_irq", {31'b0, keyIrq}, 32'h0);

        // Clear of key 1 in the cycle its press edge lands
        keyIn = 4'b1101;
        tick(9);
        clrEvt  = 1'b1;
        clrMask = 4'b0010;
        tick(1);
        clrEvt  = 1'b0;
        clrMask = '0;
        chk("collide_level", keyLevel, 32'h2);
        chk("collide_event", keyEvent, 32'h2);
        tick(1);
        chk("collide_hold", keyEvent, 32'h2);
        chk("collide_irq", {31'b0, keyIrq}, 32'h1);
        keyIn = 4'b1111;
        tick(12);
        clear(4'b0010);
        chk("collide_clr", keyEvent, 32'h0);

        // All four keys at once
        keyIn = 4'b0000;
        tick(9);
        chk("all_e9_level", keyLevel, 32'h0);
        chk("all_e9_event", keyEvent, 32'h0);
        tick(1);
        chk("all_e10_level", keyLevel, 32'hF);
        chk("all_e10_event", keyEvent, 32'hF);
        chk("all_e10_irq", {31'b0, keyIrq}, 32'h1);
        keyIn = 4'b1111;
        tick(12);
        clear(4'b1111);
        chk("all_clr", keyEvent, 32'h0);
        chk("all_clr_irq", {31'b0, keyIrq}, 32'h0);

        // Reset with key 0's count at 5 (after edge 7); release after edge 8
        keyIn = 4'b1110;
        tick(7);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);
        chk("rstmid_e10_level", keyLevel, 32'h0);
        tick(7);
        chk("rstmid_e17_level", keyLevel, 32'h0);
        tick(1);
        chk("rstmid_e18_level", keyLevel, 32'h1);
        chk("rstmid_e18_event", keyEvent, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
